pipeline_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core. Generates the stall, flush and forwarding controls for the
//  IF/ID, ID/EX and EX/MEM registers. Detects load-use hazards, redirects on a taken branch or jump, and

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/forward_unit.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects and the
// result-source code that marks a load.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding select for one EX source register.
// MEM beats WB; x0 is never forwarded.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_mem_i,
    input  logic       reg_write_mem_i,
    input  logic [4:0] rd_wb_i,
    input  logic       reg_write_wb_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_mem_i && (rd_mem_i != 5'd0) && (rd_mem_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_wb_i && (rd_wb_i != 5'd0) && (rd_wb_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage RV32I pipe.
// Define PIPE_PERF_CNT_EN to add the stall/flush/load-use performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rs1_ex,
    input  logic [4:0] rs2_ex,
    input  logic [4:0] rd_ex,
    input  logic       Reg_write_ex,
    input  logic [1:0] Result_src_ex,
    input  logic       pc_src_ex,
    input  logic [4:0] rd_mem,
    input  logic       Reg_write_mem,
    input  logic       dmem_req_mem,
    input  logic       dmem_ready,
    input  logic [4:0] rd_wb,
    input  logic       Reg_write_wb,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_ex,
    output logic [1:0] fwd_a_ex,
    output logic [1:0] fwd_b_ex,
    output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count
`endif
);

    localparam int unsigned WaitCntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic                mem_stall;
    logic                load_use;
    logic [1:0]          fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs_i            (rs1_ex),
        .rd_mem_i        (rd_mem),
        .reg_write_mem_i (Reg_write_mem),
        .rd_wb_i         (rd_wb),
        .reg_write_wb_i  (Reg_write_wb),
        .fwd_o           (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_i            (rs2_ex),
        .rd_mem_i        (rd_mem),
        .reg_write_mem_i (Reg_write_mem),
        .rd_wb_i         (rd_wb),
        .reg_write_wb_i  (Reg_write_wb),
        .fwd_o           (fwd_b)
    );

    assign load_use = (Result_src_ex == RES_SRC_LOAD) && Reg_write_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    // MEM_WAIT stalls for MEM_TIMEOUT cycles (counter 0..MEM_TIMEOUT-1); the next cycle
    // releases the pipe as if the access had completed.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        mem_stall  = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WaitCntW'(MEM_TIMEOUT))) begin
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WaitCntW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        fwd_a_ex  = FWD_RF;
        fwd_b_ex  = FWD_RF;
        mem_err   = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                // A redirect waiting in EX stays put and is acted on after the wait.
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
            end else if (pc_src_ex) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
            fwd_a_ex = fwd_a;
            fwd_b_ex = fwd_b;
            mem_err  = mem_err_q;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [CNT_W-1:0] load_use_count_q, load_use_count_d;

    // A load-use bubble is the only case that stalls ID without stalling EX.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        flush_count_d    = flush_count_q;
        load_use_count_d = load_use_count_q;
        if (stall_if) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (flush_id || flush_ex) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
        if (stall_id && !stall_ex) begin
            load_use_count_d = load_use_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q   <= '0;
            flush_count_q    <= '0;
            load_use_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            flush_count_q    <= flush_count_d;
            load_use_count_q <= load_use_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign flush_count    = flush_count_q;
    assign load_use_count = load_use_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4) with an expected-value scoreboard.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       Reg_write_ex, pc_src_ex, Reg_write_mem, dmem_req_mem, dmem_ready, Reg_write_wb;
    logic [1:0] Result_src_ex;
    logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err;
    logic [1:0] fwd_a_ex, fwd_b_ex;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_ex        (rs1_ex),
        .rs2_ex        (rs2_ex),
        .rd_ex         (rd_ex),
        .Reg_write_ex  (Reg_write_ex),
        .Result_src_ex (Result_src_ex),
        .pc_src_ex     (pc_src_ex),
        .rd_mem        (rd_mem),
        .Reg_write_mem (Reg_write_mem),
        .dmem_req_mem  (dmem_req_mem),
        .dmem_ready    (dmem_ready),
        .rd_wb         (rd_wb),
        .Reg_write_wb  (Reg_write_wb),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .stall_ex      (stall_ex),
        .stall_mem     (stall_mem),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .fwd_a_ex      (fwd_a_ex),
        .fwd_b_ex      (fwd_b_ex),
        .mem_err       (mem_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .load_use_count(load_use_count)
`endif
    );

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
        rd_ex = 5'd0; Reg_write_ex = 1'b0; Result_src_ex = 2'b00; pc_src_ex = 1'b0;
        rd_mem = 5'd0; Reg_write_mem = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
        rd_wb = 5'd0; Reg_write_wb = 1'b0;
    endtask

    task automatic load_use_x5();
        Result_src_ex = 2'b01; Reg_write_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
    endtask

    // Expected stalls {if,id,ex,mem}, flushes {id,ex}, fwd_a, fwd_b, mem_err for the current inputs.
    task automatic step(input string tag, input logic [3:0] st, input logic [1:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic err);
        exp_t e;
        exp_t got;
        logic [10:0] obs;
        e.tag = tag;
        e.v   = {st, fl, fa, fb, err};
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               fwd_a_ex, fwd_b_ex, mem_err};
        checks++;
        assert (obs === got.v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", got.tag, obs, got.v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        pc_src_ex = 1'b1; dmem_req_mem = 1'b1; rd_mem = 5'd3; Reg_write_mem = 1'b1; rs1_ex = 5'd3;
        @(posedge clk);
        #1;
        step("reset_outputs_zero", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        idle();
        step("idle_after_reset", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Load-use
        load_use_x5();
        step("load_use_rs1", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0);
        idle();
        step("load_use_bubble_gone", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        load_use_x5(); rs1_id = 5'd1; rs2_id = 5'd5;
        step("load_use_rs2", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0);
        Reg_write_ex = 1'b0;
        step("load_no_regwrite", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(); Result_src_ex = 2'b01; Reg_write_ex = 1'b1;
        step("load_rd_x0", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(); Result_src_ex = 2'b00; Reg_write_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
        step("alu_not_load", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Redirect beats load-use
        idle(); load_use_x5(); pc_src_ex = 1'b1;
        step("redirect_over_load_use", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);

        // Memory wait released by ready
        idle(); dmem_req_mem = 1'b1; dmem_ready = 1'b1;
        step("mem_ready_same_cycle", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        dmem_ready = 1'b0;
        step("mem_wait_c1", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
        load_use_x5(); pc_src_ex = 1'b1;
        step("mem_wait_c2_holds_redirect", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
        step("mem_wait_c3", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
        dmem_ready = 1'b1;
        step("mem_release_then_redirect", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
        idle();
        step("idle_after_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Timeout: entry + 4 wait cycles stall, then release with mem_err sticky
        dmem_req_mem = 1'b1;
        step("to_entry", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("to_wait_%0d", i), 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        step("to_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        idle();
        step("to_mem_err_set", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1);
        step("to_mem_err_sticky", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1);

        // Forwarding
        rd_mem = 5'd7; Reg_write_mem = 1'b1; rd_wb = 5'd7; Reg_write_wb = 1'b1;
        rs1_ex = 5'd7; rs2_ex = 5'd7;
        step("fwd_mem_priority", 4'b0000, 2'b00, 2'b10, 2'b10, 1'b1);
        Reg_write_mem = 1'b0; rs2_ex = 5'd6;
        step("fwd_wb_only", 4'b0000, 2'b00, 2'b01, 2'b00, 1'b1);
        rd_mem = 5'd0; rd_wb = 5'd0; Reg_write_mem = 1'b1; rs1_ex = 5'd0; rs2_ex = 5'd0;
        step("fwd_x0_never", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1);
        rd_mem = 5'd7; rd_wb = 5'd9; rs1_ex = 5'd9; rs2_ex = 5'd7;
        step("fwd_a_wb_b_mem", 4'b0000, 2'b00, 2'b01, 2'b10, 1'b1);

        // Reset mid MEM_WAIT, forwarding active during the stall
        rs1_ex = 5'd7; dmem_req_mem = 1'b1;
        step("fwd_during_stall", 4'b1111, 2'b00, 2'b10, 2'b10, 1'b1);
        rst = 1'b1;
        step("rst_in_mem_wait", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        idle();
        step("run_after_rst", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
